mips_multicycle_seq: RTL
========================

// Module: mips_multicycle_seq
// PURPOSE
//  Multi-cycle sequencer for the MIPS R-type datapath. Steps each instruction through FETCH/DECODE/EXEC/WB.
//  Handshakes with instruction memory. Drives the ALU select/op and register-file write enable per phase.
//  Supports a halt request and counts retired instructions. Sits between imem and the ALU/RF datapath.
// PARAMETERS
//  EXEC_CYCLES  1   ALU occupancy in cycles, range 1..15
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  start        in   1      leave IDLE/HALT and begin fetching
//  halt_req     in   1      finish current instruction, then HALT
//  imem_req     out  1      fetch request to instruction memory
//  imem_ready   in   1      imem has instr valid this cycle
//  instr        in   32     instruction word, sampled when imem_req&&imem_ready
//  ir_load      out  1      1-cycle pulse: instruction register captures instr
//  alu_op       out  4      ALU operation, valid in EXEC and WB
//  alu_a_sel    out  1      ALU A-input select (1 = alternate source)
//  rf_we        out  1      register-file write enable, WB only
//  pc_en        out  1      1-cycle pulse: PC advances
//  illegal      out  1      1-cycle pulse: op!=0 instruction discarded
//  busy         out  1      state not IDLE/HALT
//  halted       out  1      state == HALT
//  retired      out  CNT_W  count of instructions completing WB (incl. illegal)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0; retired=0. Internal IR, halt flag, exec counter cleared.
//  The reset may arrive at any point; it aborts any in-flight instruction with no RF write.
//  States: IDLE, FETCH, DECODE, EXEC, WB, HALT; Moore outputs except ir_load.
//  IDLE: start -> FETCH.
//  FETCH: imem_req=1. Wait any number of cycles. On imem_ready, ir_load=1 (same cycle), IR<=instr, -> DECODE.
//  DECODE (1 cycle): op=IR[31:26], func=IR[5:0].
//   - op!=0: illegal. Go to WB with write suppressed.
//   - op==0: alu_op<=func[3:0]. alu_a_sel<=1 iff func in 8..11, else 0. Write is enabled unless func==14.
//   - Decoded alu_op/alu_a_sel are registered, held stable through EXEC and WB.
//  EXEC: hold EXEC_CYCLES cycles using a down-counter loaded in DECODE, then -> WB.
//   - Illegal instructions skip EXEC (DECODE -> WB directly).
//  WB (1 cycle): rf_we = write enable (0 for func 14 or illegal). pc_en=1. illegal=1 if illegal.
//   - retired += 1, wrapping mod 2^CNT_W.
//   - -> HALT if halt flag set, else -> FETCH.
//  Halt flag: set by halt_req in any state except IDLE/HALT. Cleared on entering HALT.
//   - halt_req during FETCH does not cancel the pending fetch; the instruction completes.
//  HALT: halted=1. start -> FETCH (halt flag clear). halt_req ignored.
//  start while busy: ignored. start && halt_req in IDLE: start wins, flag is not set in that cycle.
//  Total latency per legal instruction after imem_ready: 1 (DECODE) + EXEC_CYCLES + 1 (WB) cycles.
//  rf_we and pc_en never asserted outside WB. imem_req never asserted outside FETCH.
// TESTING
//  1 Reset mid-EXEC with rst_n low -> state IDLE, all outputs 0, retired=0, no rf_we pulse.
//  2 start, instr=0x0000_0020 (func 32 -> alu_op 0), ready at once, EXEC_CYCLES=1:
//    ir_load c1, rf_we=1 & pc_en=1 at c4, retired=1, alu_a_sel=0.
//  3 func=9 -> alu_op=9, alu_a_sel=1 through EXEC/WB, rf_we=1.
//    func=14 -> alu_op=14, rf_we=0 in WB, pc_en=1.
//  4 instr=0x8C00_0000 (op=35) -> illegal pulse in WB, rf_we=0, no EXEC cycle, retired increments.
//  5 imem_ready held low 5 cycles -> imem_req stays 1, no state change.
//    Also assert halt_req in that window -> instr completes WB, then halted=1, imem_req=0.
//    start -> FETCH resumes.
//  6 CNT_W=4, retire 17 instrs -> retired=1 (wrap). EXEC_CYCLES=3 -> exactly 3 EXEC cycles observed.

Source files
------------

// File: rtl/mips_multicycle_seq.sv
// rtl/mips_multicycle_seq.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS R-type datapath
// Drives imem handshake, ALU select/op, RF write enable and a retired-instruction counter.
module mips_multicycle_seq #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instr,
  output logic             ir_load,
  output logic [3:0]       alu_op,
  output logic             alu_a_sel,
  output logic             rf_we,
  output logic             pc_en,
  output logic             illegal,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]       state;
  logic [5:0]       ir_op;
  logic [5:0]       ir_func;
  logic             halt_flag;
  logic [3:0]       exec_cnt;
  logic             we_r;
  logic             ill_r;
  logic [3:0]       alu_op_r;
  logic             a_sel_r;
  logic [CNT_W-1:0] ret_r;

  // Only the opcode and function fields of the instruction are ever decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir_op     <= '0;
      ir_func   <= '0;
      halt_flag <= 1'b0;
      exec_cnt  <= '0;
      we_r      <= 1'b0;
      ill_r     <= 1'b0;
      alu_op_r  <= '0;
      a_sel_r   <= 1'b0;
      ret_r     <= '0;
    end else begin
      if (halt_req && busy) halt_flag <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            ir_op   <= instr[31:26];
            ir_func <= instr[5:0];
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (ir_op != 6'd0) begin
            ill_r    <= 1'b1;
            we_r     <= 1'b0;
            alu_op_r <= '0;
            a_sel_r  <= 1'b0;
            state    <= S_WB;
          end else begin
            ill_r    <= 1'b0;
            we_r     <= (ir_func != 6'd14);
            alu_op_r <= ir_func[3:0];
            a_sel_r  <= (ir_func[5:2] == 4'b0010);
            exec_cnt <= 4'(EXEC_CYCLES - 1);
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_cnt == 4'd0) state <= S_WB;
          else exec_cnt <= exec_cnt - 4'd1;
        end
        S_WB: begin
          ret_r <= ret_r + 1'b1;
          // A request arriving in WB still lets this instruction finish first.
          if (halt_flag || halt_req) begin
            halt_flag <= 1'b0;
            state     <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign ir_load   = (state == S_FETCH) && imem_ready;
  assign alu_op    = alu_op_r;
  assign alu_a_sel = a_sel_r;
  assign rf_we     = (state == S_WB) && we_r;
  assign pc_en     = (state == S_WB);
  assign illegal   = (state == S_WB) && ill_r;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign retired   = ret_r;

endmodule
